// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the convolution layer.
//   DATA_X / DATA_Y    : input feature map rows / cols
//   K                  : square kernel side
//   NUM_FILT           : number of filters
//   CONV_X / CONV_Y    : valid-convolution output rows / cols
//   *_AW, *_W          : port widths of the scheduler / datapath interface
//   sched_state_t      : scheduler FSM state encoding
// -----------------------------------------------------------------------------
package cnn_pkg;

   localparam int DATA_X   = 28;
   localparam int DATA_Y   = 28;
   localparam int K        = 5;
   localparam int NUM_FILT = 8;
   localparam int CONV_X   = DATA_X - K + 1;
   localparam int CONV_Y   = DATA_Y - K + 1;

   localparam int DATA_AW   = 10;
   localparam int WEIGHT_AW = 8;
   localparam int FILT_W    = 3;
   localparam int COORD_W   = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_OUTPUT,
      ST_DONE
   } sched_state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// -----------------------------------------------------------------------------
// conv_addr_gen
// Tap and output-point counters plus multiplier-free address generation.
// Addresses are combinational sums of registered bases and counters, so they
// hold whenever the counters hold.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   i_clear         : zero every counter (start of a layer)
//   i_tap_adv       : step to the next kernel tap (j fastest)
//   i_pt_adv        : step to the next output point (y fastest, then x, then f)
//   o_first_tap     : current tap is tap 0
//   o_last_tap      : current tap is K*K-1
//   o_last_pt       : current point is (NUM_FILT-1, CONV_X-1, CONV_Y-1)
//   o_data_addr     : (x+i)*DATA_Y + (y+j)
//   o_weight_addr   : f*K*K + tap
//   o_filt/o_x/o_y  : current point coordinates
// -----------------------------------------------------------------------------
module conv_addr_gen
   import cnn_pkg::*;
#(
   parameter int DATA_Y   = cnn_pkg::DATA_Y,
   parameter int K        = cnn_pkg::K,
   parameter int NUM_FILT = cnn_pkg::NUM_FILT,
   parameter int CONV_X   = cnn_pkg::CONV_X,
   parameter int CONV_Y   = cnn_pkg::CONV_Y
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clear,
   input  logic                 i_tap_adv,
   input  logic                 i_pt_adv,
   output logic                 o_first_tap,
   output logic                 o_last_tap,
   output logic                 o_last_pt,
   output logic [DATA_AW-1:0]   o_data_addr,
   output logic [WEIGHT_AW-1:0] o_weight_addr,
   output logic [FILT_W-1:0]    o_filt,
   output logic [COORD_W-1:0]   o_x,
   output logic [COORD_W-1:0]   o_y
);

   localparam logic [WEIGHT_AW-1:0] TAP_LAST  = WEIGHT_AW'(K * K - 1);
   localparam logic [WEIGHT_AW-1:0] FILT_STEP = WEIGHT_AW'(K * K);
   localparam logic [COORD_W-1:0]   J_LAST    = COORD_W'(K - 1);
   localparam logic [COORD_W-1:0]   X_LAST    = COORD_W'(CONV_X - 1);
   localparam logic [COORD_W-1:0]   Y_LAST    = COORD_W'(CONV_Y - 1);
   localparam logic [FILT_W-1:0]    F_LAST    = FILT_W'(NUM_FILT - 1);
   localparam logic [DATA_AW-1:0]   ROW_STEP  = DATA_AW'(DATA_Y);
   // Moving from (x, CONV_Y-1) to (x+1, 0) adds DATA_Y - (CONV_Y-1), which is K.
   localparam logic [DATA_AW-1:0]   ROW_WRAP  = DATA_AW'(K);

   logic [WEIGHT_AW-1:0] r_tap;
   logic [COORD_W-1:0]   r_j;
   logic [DATA_AW-1:0]   r_pt_base;    // x*DATA_Y + y
   logic [DATA_AW-1:0]   r_row_base;   // r_pt_base + i*DATA_Y
   logic [WEIGHT_AW-1:0] r_filt_base;  // f*K*K
   logic [FILT_W-1:0]    r_f;
   logic [COORD_W-1:0]   r_x;
   logic [COORD_W-1:0]   r_y;
   logic [DATA_AW-1:0]   w_pt_next;

   // Base address of the following output point.
   always_comb begin
      // NOTE: default assigned first so every path drives the signal; no latch.
      w_pt_next = r_pt_base + 10'd1;
      if (r_y == Y_LAST) begin
         w_pt_next = (r_x == X_LAST) ? '0 : r_pt_base + ROW_WRAP;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst || i_clear) begin
         r_tap       <= '0;
         r_j         <= '0;
         r_pt_base   <= '0;
         r_row_base  <= '0;
         r_filt_base <= '0;
         r_f         <= '0;
         r_x         <= '0;
         r_y         <= '0;
      end else if (i_tap_adv) begin
         r_tap <= r_tap + 8'd1;
         if (r_j == J_LAST) begin
            r_j        <= '0;
            r_row_base <= r_row_base + ROW_STEP;
         end else begin
            r_j <= r_j + 5'd1;
         end
      end else if (i_pt_adv) begin
         r_tap      <= '0;
         r_j        <= '0;
         r_pt_base  <= w_pt_next;
         r_row_base <= w_pt_next;
         if (r_y != Y_LAST) begin
            r_y <= r_y + 5'd1;
         end else begin
            r_y <= '0;
            if (r_x != X_LAST) begin
               r_x <= r_x + 5'd1;
            end else begin
               r_x         <= '0;
               r_f         <= r_f + 3'd1;
               r_filt_base <= r_filt_base + FILT_STEP;
            end
         end
      end
   end

   assign o_first_tap   = (r_tap == '0);
   assign o_last_tap    = (r_tap == TAP_LAST);
   assign o_last_pt     = (r_f == F_LAST) && (r_x == X_LAST) && (r_y == Y_LAST);
   assign o_data_addr   = r_row_base + DATA_AW'(r_j);
   assign o_weight_addr = r_filt_base + r_tap;
   assign o_filt        = r_f;
   assign o_x           = r_x;
   assign o_y           = r_y;

endmodule

// File: rtl/conv_sched.sv
// -----------------------------------------------------------------------------
// conv_sched
// Scheduler for one convolution layer: for each output point (f, x, y) it
// issues K*K data/weight reads, drains the one-cycle memory latency into the
// MAC, then presents the finished point until the consumer accepts it.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : run request / run termination
//   busy, done        : run in progress / one-cycle completion pulse
//   data_rd_en/addr   : data memory read strobe and pixel address
//   weight_rd_en/addr : weight memory read strobe and address
//   mac_clear, mac_en : MAC load-instead-of-add, MAC accumulate enable
//   out_valid/ready   : finished-point handshake
//   out_filt/x/y      : coordinates of the presented point (0 when not valid)
// -----------------------------------------------------------------------------
module conv_sched
   import cnn_pkg::*;
#(
   parameter int DATA_X   = cnn_pkg::DATA_X,
   parameter int DATA_Y   = cnn_pkg::DATA_Y,
   parameter int K        = cnn_pkg::K,
   parameter int NUM_FILT = cnn_pkg::NUM_FILT,
   parameter int CONV_X   = DATA_X - K + 1,
   parameter int CONV_Y   = DATA_Y - K + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 data_rd_en,
   output logic [DATA_AW-1:0]   data_addr,
   output logic                 weight_rd_en,
   output logic [WEIGHT_AW-1:0] weight_addr,
   output logic                 mac_clear,
   output logic                 mac_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FILT_W-1:0]    out_filt,
   output logic [COORD_W-1:0]   out_x,
   output logic [COORD_W-1:0]   out_y
);

   sched_state_t r_state;
   sched_state_t w_next;

   logic                 r_mac_en;
   logic                 r_mac_clear;
   logic                 w_clear;
   logic                 w_tap_adv;
   logic                 w_pt_adv;
   logic                 w_rd_en;
   logic                 w_first_tap;
   logic                 w_last_tap;
   logic                 w_last_pt;
   logic [FILT_W-1:0]    w_filt;
   logic [COORD_W-1:0]   w_x;
   logic [COORD_W-1:0]   w_y;

   conv_addr_gen #(
      .DATA_Y   (DATA_Y),
      .K        (K),
      .NUM_FILT (NUM_FILT),
      .CONV_X   (CONV_X),
      .CONV_Y   (CONV_Y)
   ) u_addr_gen (
      .clk           (clk),
      .rst           (rst),
      .i_clear       (w_clear),
      .i_tap_adv     (w_tap_adv),
      .i_pt_adv      (w_pt_adv),
      .o_first_tap   (w_first_tap),
      .o_last_tap    (w_last_tap),
      .o_last_pt     (w_last_pt),
      .o_data_addr   (data_addr),
      .o_weight_addr (weight_addr),
      .o_filt        (w_filt),
      .o_x           (w_x),
      .o_y           (w_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_mac_en    <= 1'b0;
         r_mac_clear <= 1'b0;
      end else begin
         r_state     <= w_next;
         // Read data returns one cycle after issue; an abort cancels it.
         r_mac_en    <= w_rd_en && !abort;
         r_mac_clear <= w_rd_en && w_first_tap && !abort;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_clear   = 1'b0;
      w_tap_adv = 1'b0;
      w_pt_adv  = 1'b0;
      w_rd_en   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_next  = ST_ISSUE;
               w_clear = 1'b1;
            end
         end
         ST_ISSUE: begin
            busy    = 1'b1;
            w_rd_en = 1'b1;
            // The last tap holds its counters so the address stays put afterwards.
            if (w_last_tap) w_next = ST_DRAIN;
            else            w_tap_adv = 1'b1;
         end
         ST_DRAIN: begin
            busy   = 1'b1;
            w_next = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               if (w_last_pt) begin
                  w_next = ST_DONE;
               end else begin
                  w_next   = ST_ISSUE;
                  w_pt_adv = 1'b1;
               end
            end
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      // Abort wins over handshake and counter advance in every active state.
      if (abort && r_state != ST_IDLE) begin
         w_next    = ST_IDLE;
         w_tap_adv = 1'b0;
         w_pt_adv  = 1'b0;
      end
   end

   assign data_rd_en   = w_rd_en;
   assign weight_rd_en = w_rd_en;
   assign mac_en       = r_mac_en;
   assign mac_clear    = r_mac_clear;
   assign out_filt     = out_valid ? w_filt : '0;
   assign out_x        = out_valid ? w_x    : '0;
   assign out_y        = out_valid ? w_y    : '0;

endmodule

// File: tb/tb_conv_sched.sv
// -----------------------------------------------------------------------------
// tb_conv_sched
// Self-checking bench for conv_sched: a table of the first 30 cycles of a
// layer at default sizes, then hand-written sequences for back-pressure,
// row/filter wrap, abort and reset. A second, small instance (6x6 input? no:
// 5x6 input, 3x3 kernel, 2 filters -> 3x4 outputs, 11 cycles/point) runs a
// complete layer so the completion timing is exercised in a short run.
// -----------------------------------------------------------------------------
module tb_conv_sched;

   logic clk = 1'b0;
   logic rst, start, abort, out_ready, start_s;

   logic       busy, done, data_rd_en, weight_rd_en, mac_clear, mac_en, out_valid;
   logic [9:0] data_addr;
   logic [7:0] weight_addr;
   logic [2:0] out_filt;
   logic [4:0] out_x, out_y;

   logic       busy_s, done_s, rd_s, wrd_s, mclr_s, men_s, ov_s;
   logic [9:0] daddr_s;
   logic [7:0] waddr_s;
   logic [2:0] filt_s;
   logic [4:0] x_s, y_s;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   conv_sched dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .busy         (busy),
      .done         (done),
      .data_rd_en   (data_rd_en),
      .data_addr    (data_addr),
      .weight_rd_en (weight_rd_en),
      .weight_addr  (weight_addr),
      .mac_clear    (mac_clear),
      .mac_en       (mac_en),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_filt     (out_filt),
      .out_x        (out_x),
      .out_y        (out_y)
   );

   conv_sched #(.DATA_X(5), .DATA_Y(6), .K(3), .NUM_FILT(2)) dut_s (
      .clk          (clk),
      .rst          (rst),
      .start        (start_s),
      .abort        (abort),
      .busy         (busy_s),
      .done         (done_s),
      .data_rd_en   (rd_s),
      .data_addr    (daddr_s),
      .weight_rd_en (wrd_s),
      .weight_addr  (waddr_s),
      .mac_clear    (mclr_s),
      .mac_en       (men_s),
      .out_valid    (ov_s),
      .out_ready    (out_ready),
      .out_filt     (filt_s),
      .out_x        (x_s),
      .out_y        (y_s)
   );

   typedef struct {
      logic start;
      logic ready;
      logic busy;
      logic rd;
      int   daddr;
      int   waddr;
      logic mclr;
      logic men;
      logic ov;
   } vec_t;

   vec_t vt[30];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output bit tmo);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      tmo = (out_valid !== 1'b1);
      check("wait_out_valid", {31'd0, out_valid}, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_done"}, {31'd0, done}, 0);
      check({tag, "_rd"},   {31'd0, data_rd_en}, 0);
      check({tag, "_wrd"},  {31'd0, weight_rd_en}, 0);
      check({tag, "_mclr"}, {31'd0, mac_clear}, 0);
      check({tag, "_men"},  {31'd0, mac_en}, 0);
      check({tag, "_ov"},   {31'd0, out_valid}, 0);
   endtask

   initial begin
      #600_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit tmo;
      int ef, ex, ey, pf, px, py, dn;
      int done_cyc, last_hs, lf, lx, ly, fd, fw;
      logic b264, b265, prev_rd;

      // First 30 cycles of a layer (cycle 0 = start), default sizes.
      for (int c = 0; c < 30; c++) begin
         vt[c] = '{start: (c == 0), ready: 1'b1, busy: (c != 0), rd: 1'b0,
                   daddr: 0, waddr: 0, mclr: 1'b0, men: 1'b0, ov: 1'b0};
         if (c >= 1 && c <= 25) begin
            vt[c].rd    = 1'b1;
            vt[c].daddr = ((c - 1) / 5) * 28 + (c - 1) % 5;
            vt[c].waddr = c - 1;
            vt[c].men   = (c >= 2);
            vt[c].mclr  = (c == 2);
         end
      end
      vt[26].daddr = 116; vt[26].waddr = 24; vt[26].men = 1'b1;
      vt[27].daddr = 116; vt[27].waddr = 24; vt[27].ov  = 1'b1;
      vt[28].rd = 1'b1; vt[28].daddr = 1; vt[28].waddr = 0;
      vt[29].rd = 1'b1; vt[29].daddr = 2; vt[29].waddr = 1;
      vt[29].men = 1'b1; vt[29].mclr = 1'b1;

      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; start_s = 1'b0;
      step(); step();
      check_idle_outputs("reset");
      check("reset_daddr", {22'd0, data_addr}, 0);
      check("reset_waddr", {24'd0, weight_addr}, 0);
      check("reset_small_busy", {31'd0, busy_s}, 0);
      rst = 1'b0;
      step();

      for (int c = 0; c < 30; c++) begin
         start     = vt[c].start;
         out_ready = vt[c].ready;
         check($sformatf("t%0d_busy", c),  {31'd0, busy}, {31'd0, vt[c].busy});
         check($sformatf("t%0d_rd", c),    {31'd0, data_rd_en}, {31'd0, vt[c].rd});
         check($sformatf("t%0d_wrd", c),   {31'd0, weight_rd_en}, {31'd0, vt[c].rd});
         check($sformatf("t%0d_daddr", c), {22'd0, data_addr}, vt[c].daddr);
         check($sformatf("t%0d_waddr", c), {24'd0, weight_addr}, vt[c].waddr);
         check($sformatf("t%0d_mclr", c),  {31'd0, mac_clear}, {31'd0, vt[c].mclr});
         check($sformatf("t%0d_men", c),   {31'd0, mac_en}, {31'd0, vt[c].men});
         check($sformatf("t%0d_ov", c),    {31'd0, out_valid}, {31'd0, vt[c].ov});
         step();
      end
      start = 1'b0;

      // Back-pressure on point (0,0,1).
      out_ready = 1'b0;
      wait_valid(tmo);
      for (int k = 0; k < 10; k++) begin
         check("stall_ov",  {31'd0, out_valid}, 1);
         check("stall_y",   {27'd0, out_y}, 1);
         check("stall_x",   {27'd0, out_x}, 0);
         check("stall_rd",  {31'd0, data_rd_en}, 0);
         check("stall_men", {31'd0, mac_en}, 0);
         step();
      end
      check("stall_end_ov", {31'd0, out_valid}, 1);
      out_ready = 1'b1;
      step();
      check("resume_rd",    {31'd0, data_rd_en}, 1);
      check("resume_daddr", {22'd0, data_addr}, 2);
      check("resume_waddr", {24'd0, weight_addr}, 0);

      // Walk every point up to the first issue of (1,0,0).
      ef = 0; ex = 0; ey = 2; tmo = 1'b0;
      while (!(ef == 1 && ex == 0 && ey == 0) && !tmo) begin
         wait_valid(tmo);
         if (!tmo) begin
            check("pt_f", {29'd0, out_filt}, ef);
            check("pt_x", {27'd0, out_x}, ex);
            check("pt_y", {27'd0, out_y}, ey);
            pf = ef; px = ex; py = ey;
            ey++;
            if (ey == 24) begin
               ey = 0; ex++;
               if (ex == 24) begin ex = 0; ef++; end
            end
            step();
            check("pt_first_rd",    {31'd0, data_rd_en}, 1);
            check("pt_first_daddr", {22'd0, data_addr}, ex * 28 + ey);
            check("pt_first_waddr", {24'd0, weight_addr}, ef * 25);
            if (pf == 0 && px == 0 && py == 23)
               check("wrap_row_daddr", {22'd0, data_addr}, 28);
            if (pf == 0 && px == 23 && py == 23)
               check("wrap_filt_waddr", {24'd0, weight_addr}, 25);
         end
      end

      // Abort in the middle of ISSUE.
      step(); step(); step();
      check("pre_abort_rd", {31'd0, data_rd_en}, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_idle_outputs("abort");
      dn = 0;
      for (int k = 0; k < 5; k++) begin
         if (done === 1'b1) dn++;
         step();
      end
      check("abort_no_done", dn, 0);
      check("abort_busy_after", {31'd0, busy}, 0);

      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_busy",  {31'd0, busy}, 1);
      check("restart_rd",    {31'd0, data_rd_en}, 1);
      check("restart_daddr", {22'd0, data_addr}, 0);
      check("restart_waddr", {24'd0, weight_addr}, 0);
      out_ready = 1'b0;
      wait_valid(tmo);
      check("restart_pt_daddr_last", {22'd0, data_addr}, 116);

      // Abort together with handshake and start in OUTPUT.
      out_ready = 1'b1; abort = 1'b1; start = 1'b1;
      step();
      out_ready = 1'b0; abort = 1'b0; start = 1'b0;
      check_idle_outputs("abort_hs");
      step();
      check("abort_hs_busy2", {31'd0, busy}, 0);

      // Reset while in OUTPUT, with start held.
      start = 1'b1;
      step();
      start = 1'b0;
      wait_valid(tmo);
      check("pre_rst_daddr", {22'd0, data_addr}, 116);
      rst = 1'b1; start = 1'b1;
      step();
      check_idle_outputs("rst_mid");
      check("rst_mid_daddr", {22'd0, data_addr}, 0);
      check("rst_mid_waddr", {24'd0, weight_addr}, 0);
      check("rst_mid_coord", {19'd0, out_filt, out_x, out_y}, 0);
      step();
      check("rst_hold_busy", {31'd0, busy}, 0);
      rst = 1'b0; start = 1'b0;
      step();
      check("rst_release_busy", {31'd0, busy}, 0);
      check("rst_release_rd",   {31'd0, data_rd_en}, 0);

      // Full layer on the small instance: 24 points x 11 cycles.
      out_ready = 1'b1;
      start_s = 1'b1;
      step();
      start_s = 1'b0;
      dn = 0; done_cyc = -1; last_hs = -1; lf = -1; lx = -1; ly = -1;
      fd = -1; fw = -1; b264 = 1'bx; b265 = 1'bx; prev_rd = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         if (done_s === 1'b1) begin dn++; done_cyc = c; end
         if (c == 264) b264 = busy_s;
         if (c == 265) b265 = busy_s;
         if (ov_s === 1'b1) begin
            last_hs = c; lf = int'(filt_s); lx = int'(x_s); ly = int'(y_s);
         end
         if (rd_s === 1'b1 && prev_rd !== 1'b1) begin
            fd = int'(daddr_s); fw = int'(waddr_s);
         end
         prev_rd = rd_s;
         step();
      end
      check("small_done_count", dn, 1);
      check("small_done_cycle", done_cyc, 265);
      check("small_last_hs",    last_hs, 264);
      check("small_busy_264",   {31'd0, b264}, 1);
      check("small_busy_265",   {31'd0, b265}, 0);
      check("small_last_f",     lf, 1);
      check("small_last_x",     lx, 2);
      check("small_last_y",     ly, 3);
      check("small_last_daddr", fd, 15);
      check("small_last_waddr", fw, 9);
      check("small_idle_busy",  {31'd0, busy_s}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameters (name, default, meaning): DATA_X 28 input rows; DATA_Y 28 input cols; K 5 kernel side; NUM_FILT 8 filter count; CONV_X = DATA_X-K+1 output rows; CONV_Y = DATA_Y-K+1 output cols.
REQ-002 clk  in  1  clock; all logic rising-edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  single-cycle request to run one full layer.
REQ-005 abort  in  1  terminate current run.
REQ-006 busy  out  1  run in progress.
REQ-007 done  out  1  one-cycle pulse at normal completion.
REQ-008 data_rd_en  out  1  data memory read strobe.
REQ-009 data_addr  out  10  pixel address, row*DATA_Y+col.
REQ-010 weight_rd_en  out  1  weight memory read strobe, asserted identically to data_rd_en.
REQ-011 weight_addr  out  8  filt*K*K + i*K + j.
REQ-012 mac_clear  out  1  load the MAC accumulator with the current product instead of adding.
REQ-013 mac_en  out  1  read data valid; MAC accumulates this cycle.
REQ-014 out_valid  out  1  accumulator holds a finished output point.
REQ-015 out_ready  in  1  consumer accepts the point.
REQ-016 out_filt 3, out_x 5, out_y 5  out  coordinates of the presented point.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, OUTPUT, DONE.
REQ-018 IDLE: start=1 and abort=0 -> ISSUE, counters f=x=y=tap=0; otherwise stay.
REQ-019 ISSUE: one tap per cycle, tap=i*K+j, j fastest; data_addr=(x+i)*DATA_Y+(y+j); weight_addr=f*K*K+tap; both rd_en=1; after tap K*K-1 -> DRAIN.
REQ-020 Memory read latency is exactly 1 cycle: mac_en asserted the cycle after each issue; mac_clear=1 only with the mac_en of tap 0.
REQ-021 DRAIN: one cycle, carries mac_en for the last tap, no reads -> OUTPUT.
REQ-022 OUTPUT: out_valid=1, coordinates stable, no reads, no mac_en, until out_ready=1; on handshake advance y, wrapping to 0 with x+1 at CONV_Y-1; x wraps to 0 with f+1 at CONV_X-1; next state ISSUE, or DONE if point was (NUM_FILT-1, CONV_X-1, CONV_Y-1).
REQ-023 DONE: done=1 for one cycle, -> IDLE.
REQ-024 busy=1 in ISSUE, DRAIN, OUTPUT; 0 in IDLE, DONE.
REQ-025 Per-point latency with out_ready held high: 27 cycles (25 issue + 1 drain + 1 output).
REQ-026 start while busy ignored; out_ready outside OUTPUT ignored.
REQ-027 abort=1 in any state except IDLE -> IDLE next cycle; all outputs deasserted that cycle; no done pulse; abort overrides a simultaneous handshake and a simultaneous start.
REQ-028 Addresses are generated from incremental counters and row-base registers; no multipliers.
REQ-029 When rd_en=0, data_addr and weight_addr hold their last value.

Reset
REQ-030 rst=1 -> IDLE, all counters 0, all outputs 0, overriding every other input, including mid-run.

Structure
REQ-031 DATA_X, DATA_Y, K, NUM_FILT, CONV_X, CONV_Y and the FSM state enum reside in shared package cnn_pkg, also used by the conv datapath.
REQ-032 One sub-module conv_addr_gen (tap/point counters plus address arithmetic); the FSM stays in conv_sched.

Verification
REQ-033 Start at cycle 0, out_ready=1: cycles 1-25 data_addr 0,1,2,3,4,28..32,...,112..116, weight_addr 0..24; mac_clear at cycle 2; mac_en at cycles 2-26; out_valid at cycle 27 with (0,0,0).
REQ-034 out_ready low for 10 cycles in OUTPUT -> out_valid held, coordinates stable, no rd_en or mac_en; issue resumes the cycle after handshake.
REQ-035 Wrap: point (0,0,23) is followed by (0,1,0) with first data_addr 28; point (0,23,23) is followed by (1,0,0) with first weight_addr 25.
REQ-036 Full run, out_ready=1: last point (7,23,23) has first data_addr 667 and weight_addr 175; final handshake at cycle 124416; done=1 only at cycle 124417; busy=0 from cycle 124417.
REQ-037 abort asserted mid-ISSUE -> IDLE next cycle, no done; a new start then begins from (0,0,0).
REQ-038 rst asserted in OUTPUT -> all outputs 0 next cycle; start ignored while rst=1.
